ram_req_ctrl: RTL and testbench
===============================

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: width of RAM address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: request FIFO entries, power of 2.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1: request present.
REQ-007 SHALL have port req_ready  out  1: FIFO can accept a request.
REQ-008 SHALL have port req_wr  in  1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH: request address.
REQ-010 SHALL have port req_wdata  in  DATA_WIDTH: write data, ignored for reads.
REQ-011 SHALL have port rsp_valid  out  1: read response present.
REQ-012 SHALL have port rsp_ready  in  1: consumer accepts response.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH: read data.
REQ-014 SHALL have port rsp_addr  out  ADDR_WIDTH: address of returned read.
REQ-015 SHALL have ports ram_write_enb, ram_read_enb  out  1 each; ram_address  out  ADDR_WIDTH; ram_data_in  out  DATA_WIDTH: drive RAM write_enb, read_enb, address and data_in.
REQ-016 SHALL have port ram_data_out  in  DATA_WIDTH: RAM data_out, valid the cycle after a read_enb edge.
REQ-017 SHALL have port busy  out  1: FIFO non-empty or FSM not IDLE.

Function
REQ-018 Handshake: a request SHALL be accepted on a rising edge where req_valid && req_ready, and pushed into the FIFO.
REQ-019 req_ready SHALL equal !fifo_full, with no combinational dependence on req_valid.
REQ-020 When the FIFO is full, the requester holds its request; the block SHALL NOT drop or overwrite FIFO entries.
REQ-021 The FIFO SHALL use wrapping read and write pointers with a count 0..FIFO_DEPTH.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged.
REQ-023 The FSM SHALL have the states IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD and RESP.
REQ-024 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head, latch addr/wdata and go to ISSUE_WR or ISSUE_RD per req_wr; otherwise it stays in IDLE.
REQ-025 ISSUE_WR: ram_write_enb=1 for exactly one cycle with latched address/data; next state IDLE.
REQ-026 ISSUE_RD: ram_read_enb=1 for exactly one cycle with latched address; next state WAIT_RD.
REQ-027 WAIT_RD: on the next edge the block SHALL capture ram_data_out into rsp_rdata and the latched address into rsp_addr; next state RESP.
REQ-028 RESP: rsp_valid=1 and rsp_rdata/rsp_addr SHALL be held stable until an edge with rsp_ready=1; next state IDLE.
REQ-029 Latency from acceptance edge E0: write strobe SHALL be high in cycle E1–E2; read strobe high in E1–E2; rsp_valid high from E3.
REQ-030 All ram_* outputs SHALL be registered.
REQ-031 ram_write_enb and ram_read_enb SHALL never be high together.
REQ-032 When neither strobe is high, ram_address and ram_data_in SHALL hold their last values.
REQ-033 Requests SHALL be executed strictly in acceptance order; a read issued after a write to the same address SHALL return the new data.
REQ-034 New requests SHALL still be accepted while in RESP, up to FIFO capacity.

Reset
REQ-035 Reset assertion SHALL immediately force: FSM=IDLE; FIFO empty; req_ready=1; rsp_valid=0; busy=0; ram_write_enb=0; ram_read_enb=0; ram_address=0; ram_data_in=0; rsp_rdata=0; rsp_addr=0.
REQ-036 Reset mid-operation SHALL discard pending FIFO entries and any in-flight or unconsumed response without emitting a strobe.
REQ-037 The first request after reset deassertion SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-038 Write 0xA5 to addr 3, then read addr 3 -> one write strobe with addr=3/data=0xA5; rsp_valid from E3 with rsp_rdata=0xA5, rsp_addr=3.
REQ-039 Push 5 back-to-back reads with rsp_ready=0 -> req_ready=0 after 4 FIFO entries plus 1 in flight; no loss; 5 responses in order once rsp_ready=1.
REQ-040 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_rdata and rsp_addr stable; no new RAM strobe issued.
REQ-041 Write addr 15=0xFF, write addr 0=0x01, read 15, read 0 -> responses 0xFF then 0x01; strobes never overlap.
REQ-042 Assert reset during WAIT_RD with 2 entries queued -> all outputs at reset values within the same cycle; no response after release.
REQ-043 Push and pop in the same cycle at count=2 -> count stays 2; req_ready stays 1.

Source files
------------

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: queues RAM read/write requests in a small FIFO and
// issues them in order to a single-port RAM, returning read data.
// Ports:
//   clk, reset              clock, async active-high reset
//   req_valid/ready/wr/addr/wdata   request handshake and payload
//   rsp_valid/ready/rdata/addr      read response handshake and payload
//   ram_write_enb, ram_read_enb, ram_address, ram_data_in  RAM drive
//   ram_data_out            RAM read data, valid the cycle after read_enb
//   busy                    FIFO non-empty or sequencer active
module ram_req_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  ram_write_enb,
  output logic                  ram_read_enb,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RD,
    RESP
  } state_t;

  req_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;
  req_t             head;

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Strobes are decided one state early so they leave a flop
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rsp_addr_d = rsp_addr_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          addr_d = head.addr;
          if (head.wr) begin
            wdata_d = head.data;
            wr_en_d = 1'b1;
            state_d = ISSUE_WR;
          end else begin
            rd_en_d = 1'b1;
            state_d = ISSUE_RD;
          end
        end
      end
      ISSUE_WR: state_d = IDLE;
      ISSUE_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        rdata_d    = ram_data_out;
        rsp_addr_d = addr_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload storage needs no reset: count_q alone decides validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_wr, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rsp_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rsp_addr_q <= rsp_addr_d;
    end
  end

  assign ram_write_enb = wr_en_q;
  assign ram_read_enb  = rd_en_q;
  assign ram_address   = addr_q;
  assign ram_data_in   = wdata_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_addr      = rsp_addr_q;
  assign busy          = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: randomized bench for ram_req_ctrl with a
// behavioural RAM and an in-order request/response reference model.
module tb_ram_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NW = 1 << AW;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          ram_write_enb, ram_read_enb;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;
  logic          busy;

  ram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .ram_write_enb(ram_write_enb), .ram_read_enb(ram_read_enb),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit overlap_seen = 1'b0;
  logic [DW-1:0] ram_mem [NW];
  logic [DW-1:0] model_mem [NW];
  ev_t  wr_log [$];
  ev_t  rd_log [$];
  rsp_t rsp_log [$];
  rsp_t exp_rsp [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM
  always @(posedge clk) begin
    if (ram_read_enb) ram_data_out <= ram_mem[ram_address];
    if (ram_write_enb) ram_mem[ram_address] = ram_data_in;
  end

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    ev_t  e;
    rsp_t r;
    if (!reset) begin
      e.cyc = cyc;
      e.addr = ram_address;
      e.data = ram_data_in;
      if (ram_write_enb && ram_read_enb) overlap_seen = 1'b1;
      if (ram_write_enb) wr_log.push_back(e);
      if (ram_read_enb) rd_log.push_back(e);
      if (rsp_valid && rsp_ready) begin
        r.addr = rsp_addr;
        r.data = rsp_rdata;
        rsp_log.push_back(r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output bit ok,
                      output int acc_cyc, output int waited);
    rsp_t e;
    ok = 1'b0;
    acc_cyc = 0;
    waited = 0;
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_wdata = d;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        if (wr) begin
          model_mem[a] = d;
        end else begin
          e.addr = a;
          e.data = model_mem[a];
          exp_rsp.push_back(e);
        end
        step();
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      step();
      waited++;
    end
  endtask

  task automatic collect(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [4+2*AW+2*DW:0] snap;
    #1 reset = 1'b1;
    #1;
    snap = {req_ready, rsp_valid, busy, ram_write_enb, ram_read_enb,
            ram_address, ram_data_in, rsp_rdata, rsp_addr};
    checks++;
    if (snap !== {1'b1, {(4+2*AW+2*DW){1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", snap,
               {1'b1, {(4+2*AW+2*DW){1'b0}}});
    end
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b expected 1 0",
               req_ready, busy);
    end
  endtask

  task automatic test_write_read();
    bit ok, ok2;
    int acc_w, acc_r, wt, rise;
    rsp_t x;
    rsp_ready = 1'b0;
    wait_idle(ok);
    wr_log.delete();
    rd_log.delete();
    send(1'b1, 4'd3, 8'hA5, ok, acc_w, wt);
    req_valid = 1'b0;
    wait_idle(ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL wr_accept: ok=%b idle=%b expected 1 1", ok, ok2);
    end
    send(1'b0, 4'd3, 8'h00, ok, acc_r, wt);
    req_valid = 1'b0;
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        rise = cyc;
        break;
      end
      step();
    end
    checks++;
    if (wr_log.size() !== 1) begin
      errors++;
      $display("FAIL wr_strobe_count: got %0d expected 1", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0].addr !== 4'd3 || wr_log[0].data !== 8'hA5) begin
        errors++;
        $display("FAIL wr_strobe_payload: got %h/%h expected 3/a5",
                 wr_log[0].addr, wr_log[0].data);
      end
      checks++;
      if (wr_log[0].cyc !== acc_w + 1) begin
        errors++;
        $display("FAIL wr_latency: strobe cycle %0d expected %0d",
                 wr_log[0].cyc, acc_w + 1);
      end
    end
    checks++;
    if (rd_log.size() !== 1) begin
      errors++;
      $display("FAIL rd_strobe_count: got %0d expected 1", rd_log.size());
    end else begin
      checks++;
      if (rd_log[0].cyc !== acc_r + 1 || rd_log[0].addr !== 4'd3) begin
        errors++;
        $display("FAIL rd_strobe: cycle %0d addr %h expected %0d 3",
                 rd_log[0].cyc, rd_log[0].addr, acc_r + 1);
      end
    end
    checks++;
    if (rise !== acc_r + 3) begin
      errors++;
      $display("FAIL rsp_latency: rsp_valid at %0d expected %0d",
               rise, acc_r + 3);
    end
    checks++;
    if (rsp_rdata !== 8'hA5 || rsp_addr !== 4'd3) begin
      errors++;
      $display("FAIL rsp_data: got %h@%h expected a5@3",
               rsp_rdata, rsp_addr);
    end
    rsp_ready = 1'b1;
    collect(1, ok);
    checks++;
    if (!ok || rsp_log.size() !== exp_rsp.size()) begin
      errors++;
      $display("FAIL wr_rd_rsp_count: got %0d expected %0d",
               rsp_log.size(), exp_rsp.size());
    end
    while (rsp_log.size() > 0 && exp_rsp.size() > 0) begin
      x = exp_rsp.pop_front();
      checks++;
      if (rsp_log[0].addr !== x.addr || rsp_log[0].data !== x.data) begin
        errors++;
        $display("FAIL wr_rd_rsp: got %h@%h expected %h@%h",
                 rsp_log[0].data, rsp_log[0].addr, x.data, x.addr);
      end
      void'(rsp_log.pop_front());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc, wt, nok;
    rsp_t x;
    rsp_ready = 1'b0;
    wait_idle(ok);
    rd_log.delete();
    rsp_log.delete();
    exp_rsp.delete();
    nok = 0;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, AW'($urandom), 8'h00, ok, acc, wt);
      if (ok && wt == 0) nok++;
    end
    req_valid = 1'b0;
    checks++;
    if (nok !== 5) begin
      errors++;
      $display("FAIL bp_accept: %0d of 5 accepted back-to-back", nok);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: req_ready=%b expected 0", req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp[0].data ||
          rsp_addr !== exp_rsp[0].addr || rd_log.size() !== 1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b %h@%h rd=%0d expected 1 %h@%h 1",
                 i, rsp_valid, rsp_rdata, rsp_addr, rd_log.size(),
                 exp_rsp[0].data, exp_rsp[0].addr);
      end
      step();
    end
    rsp_ready = 1'b1;
    collect(5, ok);
    checks++;
    if (!ok || rsp_log.size() !== 5 || rd_log.size() !== 5) begin
      errors++;
      $display("FAIL bp_count: rsp=%0d rd=%0d expected 5 5",
               rsp_log.size(), rd_log.size());
    end
    while (rsp_log.size() > 0 && exp_rsp.size() > 0) begin
      x = exp_rsp.pop_front();
      checks++;
      if (rsp_log[0].addr !== x.addr || rsp_log[0].data !== x.data) begin
        errors++;
        $display("FAIL bp_rsp: got %h@%h expected %h@%h",
                 rsp_log[0].data, rsp_log[0].addr, x.data, x.addr);
      end
      void'(rsp_log.pop_front());
    end
  endtask

  task automatic test_order();
    bit ok;
    int acc, wt;
    rsp_ready = 1'b1;
    wait_idle(ok);
    rsp_log.delete();
    exp_rsp.delete();
    overlap_seen = 1'b0;
    send(1'b1, 4'd15, 8'hFF, ok, acc, wt);
    send(1'b1, 4'd0, 8'h01, ok, acc, wt);
    send(1'b0, 4'd15, 8'h00, ok, acc, wt);
    send(1'b0, 4'd0, 8'h00, ok, acc, wt);
    req_valid = 1'b0;
    collect(2, ok);
    checks++;
    if (!ok || rsp_log.size() !== 2) begin
      errors++;
      $display("FAIL order_count: got %0d expected 2", rsp_log.size());
    end else begin
      checks++;
      if (rsp_log[0].data !== 8'hFF || rsp_log[0].addr !== 4'd15 ||
          rsp_log[1].data !== 8'h01 || rsp_log[1].addr !== 4'd0) begin
        errors++;
        $display("FAIL order_rsp: got %h@%h %h@%h expected ff@f 01@0",
                 rsp_log[0].data, rsp_log[0].addr,
                 rsp_log[1].data, rsp_log[1].addr);
      end
    end
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++;
      $display("FAIL order_overlap: both strobes high together");
    end
    rsp_log.delete();
    exp_rsp.delete();
  endtask

  task automatic test_random();
    bit ok, done;
    int acc, wt, nok;
    rsp_t x;
    wait_idle(ok);
    rsp_log.delete();
    exp_rsp.delete();
    overlap_seen = 1'b0;
    done = 1'b0;
    nok = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(1'($urandom_range(0, 1)), AW'($urandom),
               DW'($urandom), ok, acc, wt);
          if (ok) nok++;
          if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            step();
          end
        end
        req_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    rsp_ready = 1'b1;
    checks++;
    if (nok !== 40) begin
      errors++;
      $display("FAIL rand_accept: %0d of 40 accepted", nok);
    end
    collect(exp_rsp.size(), ok);
    checks++;
    if (!ok || rsp_log.size() !== exp_rsp.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d expected %0d",
               rsp_log.size(), exp_rsp.size());
    end
    while (rsp_log.size() > 0 && exp_rsp.size() > 0) begin
      x = exp_rsp.pop_front();
      checks++;
      if (rsp_log[0].addr !== x.addr || rsp_log[0].data !== x.data) begin
        errors++;
        $display("FAIL rand_rsp: got %h@%h expected %h@%h",
                 rsp_log[0].data, rsp_log[0].addr, x.data, x.addr);
      end
      void'(rsp_log.pop_front());
    end
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++;
      $display("FAIL rand_overlap: both strobes high together");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int acc, wt, nwr, nrd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [4+2*AW+2*DW:0] snap;
    rsp_t x;
    rsp_ready = 1'b0;
    wait_idle(ok);
    rsp_log.delete();
    exp_rsp.delete();
    send(1'b0, AW'($urandom), 8'h00, ok, acc, wt);
    send(1'b1, AW'($urandom), DW'($urandom), ok, acc, wt);
    send(1'b0, AW'($urandom), 8'h00, ok, acc, wt);
    req_valid = 1'b0;
    nwr = wr_log.size();
    nrd = rd_log.size();
    reset = 1'b1;
    #1;
    snap = {req_ready, rsp_valid, busy, ram_write_enb, ram_read_enb,
            ram_address, ram_data_in, rsp_rdata, rsp_addr};
    checks++;
    if (snap !== {1'b1, {(4+2*AW+2*DW){1'b0}}}) begin
      errors++;
      $display("FAIL midreset_values: got %h expected %h", snap,
               {1'b1, {(4+2*AW+2*DW){1'b0}}});
    end
    step();
    reset = 1'b0;
    exp_rsp.delete();
    rsp_log.delete();
    for (int i = 0; i < NW; i++) model_mem[i] = ram_mem[i];
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (rsp_log.size() !== 0 || wr_log.size() !== nwr ||
        rd_log.size() !== nrd || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: rsp=%0d wr=%0d rd=%0d busy=%b exp 0 %0d %0d 0",
               rsp_log.size(), wr_log.size(), rd_log.size(), busy, nwr, nrd);
    end
    a = AW'($urandom);
    d = DW'($urandom);
    send(1'b1, a, d, ok, acc, wt);
    checks++;
    if (!ok || wt !== 0) begin
      errors++;
      $display("FAIL first_after_reset: ok=%b waited=%0d expected 1 0",
               ok, wt);
    end
    send(1'b0, a, 8'h00, ok, acc, wt);
    req_valid = 1'b0;
    collect(1, ok);
    checks++;
    if (!ok || rsp_log.size() !== 1) begin
      errors++;
      $display("FAIL after_reset_count: got %0d expected 1", rsp_log.size());
    end
    while (rsp_log.size() > 0 && exp_rsp.size() > 0) begin
      x = exp_rsp.pop_front();
      checks++;
      if (rsp_log[0].addr !== x.addr || rsp_log[0].data !== x.data ||
          x.data !== d) begin
        errors++;
        $display("FAIL after_reset_rsp: got %h@%h expected %h@%h",
                 rsp_log[0].data, rsp_log[0].addr, d, a);
      end
      void'(rsp_log.pop_front());
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    int acc, wt;
    rsp_t x;
    rsp_ready = 1'b0;
    wait_idle(ok);
    rsp_log.delete();
    exp_rsp.delete();
    for (int i = 0; i < 3; i++) send(1'b0, AW'($urandom), 8'h00, ok, acc, wt);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (dut.count_q !== 3'd2 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_setup: count=%0d rsp_valid=%b expected 2 0",
               dut.count_q, rsp_valid);
    end
    send(1'b0, AW'($urandom), 8'h00, ok, acc, wt);
    req_valid = 1'b0;
    checks++;
    if (!ok || dut.count_q !== 3'd2 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_pop: ok=%b count=%0d ready=%b expected 1 2 1",
               ok, dut.count_q, req_ready);
    end
    rsp_ready = 1'b1;
    collect(4, ok);
    checks++;
    if (!ok || rsp_log.size() !== 4) begin
      errors++;
      $display("FAIL pp_count: got %0d expected 4", rsp_log.size());
    end
    while (rsp_log.size() > 0 && exp_rsp.size() > 0) begin
      x = exp_rsp.pop_front();
      checks++;
      if (rsp_log[0].addr !== x.addr || rsp_log[0].data !== x.data) begin
        errors++;
        $display("FAIL pp_rsp: got %h@%h expected %h@%h",
                 rsp_log[0].data, rsp_log[0].addr, x.data, x.addr);
      end
      void'(rsp_log.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      ram_mem[i] = DW'($urandom);
      model_mem[i] = ram_mem[i];
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_order();
    test_random();
    test_reset_mid();
    test_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
